nbiot_ul_descrambler: RTL

Serial Gold-sequence descrambler for the NB-IoT uplink receive path. It regenerates the 3GPP 36.211 §7.2 pseudo-random sequence c(n) from a supplied c_init and XORs it bit by bit onto a received hard-bit stream. This undoes the scrambling applied on the transmit side. It sits between the demapper and the rate-dematcher, and uses valid/ready handshakes on both sides. Unlike the transmit-side generator, which builds the whole sequence in parallel, this block runs two 31-bit LFSRs, one step per transferred bit.

---
 rtl/nbiot_ul_descrambler_if.sv | 27 ++
 rtl/nbiot_ul_descrambler.sv | 103 ++++++++++
 2 files changed

// File: rtl/nbiot_ul_descrambler_if.sv
// Handshake and control bundle for the NB-IoT uplink descrambler.
// The master side drives requests and input bits; the slave side is the descrambler.
interface nbiot_ul_descrambler_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [30:0]      c_init;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, c_init, len, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, busy, done
  );

  modport slave (
    input  start, c_init, len, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, busy, done
  );
endinterface

// File: rtl/nbiot_ul_descrambler.sv
// Serial Gold-sequence descrambler: two 31-bit LFSRs stepped once per accepted bit,
// after an NC-step warm-up, XOR c(n) onto the received hard-bit stream.
//
// state | meaning
// IDLE  | waiting for start with len != 0
// WARM  | stepping both LFSRs every cycle to discard the first NC outputs
// RUN   | stepping once per accepted input bit until len bits are taken
module nbiot_ul_descrambler #(
  parameter int NC    = 1600,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  nbiot_ul_descrambler_if.slave   bus
);
  localparam int WARM_W = $clog2(NC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [30:0]      x1_q, x2_q;
  logic [CNT_W-1:0] len_q, bit_cnt_q;
  logic [WARM_W-1:0] warm_cnt_q;
  logic             out_valid_q, out_bit_q, done_q;

  logic c_bit, in_ready, accept, last_bit, load, step, warm_tc;

  assign c_bit    = x1_q[0] ^ x2_q[0];
  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign last_bit = (bit_cnt_q == len_q - CNT_W'(1));
  assign warm_tc  = (warm_cnt_q == WARM_W'(NC - 1));
  assign step     = (state_q == WARM) || accept;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          load    = 1'b1;
          state_d = WARM;
        end
      end
      WARM: if (warm_tc) state_d = RUN;
      RUN:  if (accept && last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // LFSR windows: bit 0 is x(n), new bit enters at position 30.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q       <= '0;
      x2_q       <= '0;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      warm_cnt_q <= '0;
    end else if (load) begin
      x1_q       <= 31'h1;
      x2_q       <= bus.c_init;
      len_q      <= bus.len;
      bit_cnt_q  <= '0;
      warm_cnt_q <= '0;
    end else if (step) begin
      x1_q <= {x1_q[3] ^ x1_q[0], x1_q[30:1]};
      x2_q <= {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
      if (state_q == WARM) warm_cnt_q <= warm_cnt_q + WARM_W'(1);
      if (accept)          bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= accept && last_bit;
      if (accept) begin
        out_bit_q   <= bus.in_bit ^ c_bit;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule
